// File: rtl/otdr_shot_sequencer.sv
// otdr_shot_sequencer: per-shot OTDR acquisition sequencer.
// Fires the laser, waits out the dead zone, then enables the downstream
// 8-bit sample counter and counts 256-sample pages via its carry, repeating
// for the programmed number of shots with a fixed idle gap between shots.
// Optional feature macro: OTDR_ABORT_EN adds an 'abort' input that ends the
// run early through a final GAP and DONE.
module otdr_shot_sequencer #(
  parameter int GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  pulse_len,
  input  logic [7:0]  dead_len,
  input  logic [7:0]  num_pages,
  input  logic [15:0] num_shots,
  input  logic        cnt_carry,
`ifdef OTDR_ABORT_EN
  input  logic        abort,
`endif
  output logic        cnt_en,
  output logic        cnt_clr,
  output logic        laser_pulse,
  output logic        acq_valid,
  output logic [7:0]  page_idx,
  output logic [15:0] shot_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PULSE = 3'd1,
    DEAD  = 3'd2,
    ACQ   = 3'd3,
    GAP   = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Output bundle; always equals decode(state), but kept in flops so the
  // ports come straight from registers.
  typedef struct packed {
    logic laser;
    logic en;
    logic clr;
    logic busy;
    logic done;
  } outs_t;

  // GAP lasts GAP_CYC cycles, so the down-timer is loaded with one less.
  localparam logic [15:0] GAP_M1 = 16'(GAP_CYC - 1);

  state_t      state;
  outs_t       outs;
  logic [15:0] timer;
  logic [7:0]  pulse_m1;
  logic [7:0]  dead_r;
  logic [7:0]  pages_m1;
  logic [15:0] shots_m1;
  logic        aborted;
  logic        abort_hit;

  // Moore output decode per state. busy drops in DONE so that it falls in
  // the same cycle that done rises.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      PULSE: begin
        o.laser = 1'b1;
        o.clr   = 1'b1;
        o.busy  = 1'b1;
      end
      DEAD: begin
        o.clr  = 1'b1;
        o.busy = 1'b1;
      end
      ACQ: begin
        o.en   = 1'b1;
        o.busy = 1'b1;
      end
      GAP: begin
        o.clr  = 1'b1;
        o.busy = 1'b1;
      end
      DONE: begin
        o.done = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // Zero-valued counts are treated as one, so store "count minus one" with
  // saturation at zero.
  function automatic logic [7:0] sat_m1_8(input logic [7:0] v);
    return (v == 8'd0) ? 8'd0 : v - 8'd1;
  endfunction

  function automatic logic [15:0] sat_m1_16(input logic [15:0] v);
    return (v == 16'd0) ? 16'd0 : v - 16'd1;
  endfunction

`ifdef OTDR_ABORT_EN
  // DONE is already finishing the run, so an abort there changes nothing.
  assign abort_hit = abort && (state != IDLE) && (state != DONE);
`else
  assign abort_hit = 1'b0;
`endif

  assign laser_pulse = outs.laser;
  assign cnt_en      = outs.en;
  assign acq_valid   = outs.en;
  assign cnt_clr     = outs.clr;
  assign busy        = outs.busy;
  assign done        = outs.done;

  // Shot sequencer: state, shared down-timer, page/shot indices, latched config.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      outs     <= '0;
      timer    <= 16'd0;
      page_idx <= 8'd0;
      shot_idx <= 16'd0;
      pulse_m1 <= 8'd0;
      dead_r   <= 8'd0;
      pages_m1 <= 8'd0;
      shots_m1 <= 16'd0;
      aborted  <= 1'b0;
    end else if (abort_hit) begin
      state    <= GAP;
      outs     <= decode(GAP);
      timer    <= GAP_M1;
      page_idx <= 8'd0;
      aborted  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pulse_m1 <= sat_m1_8(pulse_len);
            dead_r   <= dead_len;
            pages_m1 <= sat_m1_8(num_pages);
            shots_m1 <= sat_m1_16(num_shots);
            shot_idx <= 16'd0;
            page_idx <= 8'd0;
            aborted  <= 1'b0;
            timer    <= {8'd0, sat_m1_8(pulse_len)};
            state    <= PULSE;
            outs     <= decode(PULSE);
          end
        end

        PULSE: begin
          if (timer == 16'd0) begin
            if (dead_r == 8'd0) begin
              state <= ACQ;
              outs  <= decode(ACQ);
            end else begin
              timer <= {8'd0, dead_r - 8'd1};
              state <= DEAD;
              outs  <= decode(DEAD);
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        DEAD: begin
          if (timer == 16'd0) begin
            state <= ACQ;
            outs  <= decode(ACQ);
          end else begin
            timer <= timer - 16'd1;
          end
        end

        ACQ: begin
          if (cnt_carry) begin
            if (page_idx == pages_m1) begin
              page_idx <= 8'd0;
              timer    <= GAP_M1;
              state    <= GAP;
              outs     <= decode(GAP);
            end else begin
              page_idx <= page_idx + 8'd1;
            end
          end
        end

        GAP: begin
          if (timer == 16'd0) begin
            if (aborted || (shot_idx == shots_m1)) begin
              state <= DONE;
              outs  <= decode(DONE);
            end else begin
              shot_idx <= shot_idx + 16'd1;
              timer    <= {8'd0, pulse_m1};
              state    <= PULSE;
              outs     <= decode(PULSE);
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end

        DONE: begin
          state <= IDLE;
          outs  <= decode(IDLE);
        end

        default: begin
          state <= IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

endmodule
